// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/ready/done handshake and operand/product bus for seq_multiplier
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, x, y,
        input  ready, done, product
    );

    modport slave (
        input  start, x, y,
        output ready, done, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add multiplier, one partial product per clock
// Optional signed (two's complement) mode via SEQ_MULTIPLIER_SIGNED_EN.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        FIX  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic                 neg_q, neg_d;
`endif

    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     step_acc;
    logic [WIDTH-1:0]     step_mplier;
    logic                 ready;

    assign ready       = (state_q == IDLE) || (state_q == DONE);
    assign bus.ready   = ready;
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

    // Upper half plus carry absorbs the multiplicand; the low half only shifts.
    always_comb begin
        sum = acc_q[2*WIDTH:WIDTH];
        if (mplier_q[0]) begin
            sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end
        step_acc    = {sum, acc_q[WIDTH-1:0]} >> 1;
        step_mplier = {acc_q[0], mplier_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    acc_d   = '0;
                    cnt_d   = CNT_INIT;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                    mcand_d  = bus.x[WIDTH-1] ? -bus.x : bus.x;
                    mplier_d = bus.y[WIDTH-1] ? -bus.y : bus.y;
                    neg_d    = bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
`else
                    mcand_d  = bus.x;
                    mplier_d = bus.y;
`endif
                end
            end
            RUN: begin
                acc_d    = step_acc;
                mplier_d = step_mplier;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                    state_d = FIX;
`else
                    state_d   = DONE;
                    product_d = step_acc[2*WIDTH-1:0];
`endif
                end
            end
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            FIX: begin
                state_d   = DONE;
                product_d = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier with randomized operands
module tb_seq_multiplier;
    localparam int W = 8;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   acc_q[$];
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_prod = '0;
    int   last_acc = 0;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'(a) * longint'(b);
`endif
        return p[2*W-1:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] e);
        int n = 0;
        while (!bus.ready && n < 4 * W) begin
            idle(1);
            n++;
        end
        if (!bus.ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL ready_timeout: ready stuck low for %0d cycles", n);
            return;
        end
        bus.start = 1'b1;
        bus.x = a;
        bus.y = b;
        idle(1);
        acc_q.push_back(cyc);
        exp_q.push_back(e);
        last_acc = cyc;
        bus.start = 1'b0;
        bus.x = W'($urandom);
        bus.y = W'($urandom);
    endtask

    // Monitor: ready/done timing and product value/stability from the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_ready;
            exp_ready = !(acc_q.size() > 0 && (cyc - acc_q[0]) < LAT);
            n_vec++;
            if (bus.ready !== exp_ready) begin
                n_fail++;
                $display("FAIL ready: got %0b, expected %0b at cycle %0d", bus.ready, exp_ready, cyc);
            end
            if (bus.done) begin
                if (acc_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: product %0h at cycle %0d", bus.product, cyc);
                end else begin
                    n_vec++;
                    if (cyc - acc_q[0] != LAT) begin
                        n_fail++;
                        $display("FAIL latency: got %0d, expected %0d", cyc - acc_q[0], LAT);
                    end
                    n_vec++;
                    if (bus.product !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL product: got %0h, expected %0h", bus.product, exp_q[0]);
                    end
                    last_prod = exp_q[0];
                    void'(acc_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end else begin
                if (acc_q.size() > 0 && (cyc - acc_q[0]) >= LAT) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL missing_done: expected product %0h at cycle %0d", exp_q[0], cyc);
                    void'(acc_q.pop_front());
                    void'(exp_q.pop_front());
                end
                n_vec++;
                if (bus.product !== last_prod) begin
                    n_fail++;
                    $display("FAIL product_hold: got %0h, expected %0h", bus.product, last_prod);
                end
            end
        end
    end

    initial begin
        int first;
        int n;
        logic [W-1:0] a, b;
        logic [W-1:0] edge_vals[4];
        edge_vals[0] = '0;
        edge_vals[1] = '1;
        edge_vals[2] = W'(1);
        edge_vals[3] = {1'b1, {(W-1){1'b0}}};

        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
        idle(2);
        check("reset_ready", longint'(bus.ready), 1);
        check("reset_done", longint'(bus.done), 0);
        check("reset_product", longint'(bus.product), 0);

        // start held while reset releases: taken on the first edge out of reset
        bus.start = 1'b1;
        bus.x = 8'd13;
        bus.y = 8'd11;
        rst = 1'b0;
        idle(1);
        acc_q.push_back(cyc);
        exp_q.push_back(16'd143);
        bus.start = 1'b0;
        bus.x = 8'd77;
        bus.y = 8'd200;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
        issue(8'd255, 8'd255, 16'h0001);
`else
        issue(8'd255, 8'd255, 16'hFE01);
`endif
        issue(8'd0, 8'd200, 16'd0);

        issue(8'd6, 8'd7, 16'd42);
        first = last_acc;
        idle(2);
        bus.start = 1'b1;
        bus.x = 8'd9;
        bus.y = 8'd9;
        idle(1);
        bus.start = 1'b0;
        issue(8'd9, 8'd9, 16'd81);
        check("back_to_back_gap", longint'(last_acc - first), longint'(LAT + 1));

        issue(8'd5, 8'd5, 16'd25);
        idle(LAT + 2);
        issue(8'd10, 8'd10, 16'd100);
        idle(3);
        rst = 1'b1;
        acc_q.delete();
        exp_q.delete();
        last_prod = '0;
        #1;
        check("abort_product", longint'(bus.product), 0);
        check("abort_ready", longint'(bus.ready), 1);
        check("abort_done", longint'(bus.done), 0);
        idle(2);
        rst = 1'b0;
        idle(LAT + 4);
        issue(8'd3, 8'd4, 16'd12);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
        issue(8'hFD, 8'd5, 16'hFFF1);
        issue(8'h80, 8'h80, 16'h4000);
        issue(8'h7F, 8'h80, 16'hC080);
`endif

        for (int i = 0; i < 200; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap > 0) idle(gap);
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) a = edge_vals[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) b = edge_vals[$urandom_range(0, 3)];
            issue(a, b, model(a, b));
        end

        n = 0;
        while (acc_q.size() > 0 && n < 4 * W) begin
            idle(1);
            n++;
        end
        if (acc_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding", acc_q.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
